// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcode
// classes, opcode constants, pc_sel codes, ALU codes and trap causes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP,
        S_HALT
    } state_e;

    typedef enum logic [3:0] {
        CLS_RALU,
        CLS_IALU,
        CLS_LW,
        CLS_SW,
        CLS_BR,
        CLS_J,
        CLS_NOP,
        CLS_HALT,
        CLS_ILL
    } op_class_e;

    localparam logic [4:0] OP_LW   = 5'h18;
    localparam logic [4:0] OP_SW   = 5'h19;
    localparam logic [4:0] OP_BEQ  = 5'h1A;
    localparam logic [4:0] OP_BNE  = 5'h1B;
    localparam logic [4:0] OP_J    = 5'h1C;
    localparam logic [4:0] OP_ILL  = 5'h1D;
    localparam logic [4:0] OP_NOP  = 5'h1E;
    localparam logic [4:0] OP_HALT = 5'h1F;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;

    localparam logic [2:0] PCSEL_INC    = 3'd0;
    localparam logic [2:0] PCSEL_BRANCH = 3'd1;
    localparam logic [2:0] PCSEL_JUMP   = 3'd2;
    localparam logic [2:0] PCSEL_TRAP   = 3'd4;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_BUS     = 2'd2;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode classifier. Any set bit above op[4] makes the
// opcode illegal, as does the reserved code 1D.
module op_class_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0] op,
    output op_class_e       op_class
);

    logic       upper_nz;
    logic [4:0] op5;

    // Map the opcode onto its instruction class.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        op_class = CLS_ILL;
        upper_nz = |(op & ~OP_W'(5'h1F));
        op5      = op[4:0];
        if (upper_nz) begin
            op_class = CLS_ILL;
        end else if (!op5[4]) begin
            op_class = CLS_RALU;
        end else if (!op5[3]) begin
            op_class = CLS_IALU;
        end else begin
            unique case (op5)
                OP_LW:           op_class = CLS_LW;
                OP_SW:           op_class = CLS_SW;
                OP_BEQ, OP_BNE:  op_class = CLS_BR;
                OP_J:            op_class = CLS_J;
                OP_NOP:          op_class = CLS_NOP;
                OP_HALT:         op_class = CLS_HALT;
                default:         op_class = CLS_ILL;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, with a
// bus-timeout trap in FETCH/MEM, an illegal-opcode trap and a HALT state.
// Strobes are decoded from the registered state plus the latched opcode.
module multicycle_control
    import multicycle_ctrl_pkg::*;
#(
    parameter int OP_W      = 5,
    parameter int ALUC_W    = 4,
    parameter int PCSEL_W   = 3,
    parameter int USE_READY = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic [PCSEL_W-1:0] pc_sel,
    output logic               pc_write,
    output logic               ir_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic               reg_write,
    output logic [ALUC_W-1:0]  alu_ctrl,
    output logic               halted,
    output logic [1:0]         trap_cause
);

    state_e          state_q;
    logic [7:0]      wait_q;
    logic [OP_W-1:0] op_q;
    logic [1:0]      trap_cause_q;
    op_class_e       live_cls;
    op_class_e       op_cls;
    logic            ready_eff;
    logic            timed_out;
    logic            br_taken;

    op_class_decode #(.OP_W(OP_W)) u_dec_live (.op(op),   .op_class(live_cls));
    op_class_decode #(.OP_W(OP_W)) u_dec_q    (.op(op_q), .op_class(op_cls));

    assign ready_eff  = (USE_READY != 0) ? mem_ready : 1'b1;
    assign timed_out  = !ready_eff && (wait_q == 8'(TIMEOUT));
    assign br_taken   = (op_q[4:0] == OP_BNE) ? !alu_zero : alu_zero;
    assign trap_cause = trap_cause_q;

    // State register, opcode latch, wait counter and sticky trap cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            wait_q       <= '0;
            op_q         <= '0;
            trap_cause_q <= TRAP_NONE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            wait_q <= '0;
            unique case (state_q)
                S_FETCH: begin
                    if (ready_eff) begin
                        state_q <= S_DECODE;
                    end else if (timed_out) begin
                        state_q      <= S_TRAP;
                        trap_cause_q <= TRAP_BUS;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_DECODE: begin
                    op_q <= op;
                    unique case (live_cls)
                        CLS_NOP:  state_q <= S_FETCH;
                        CLS_HALT: state_q <= S_HALT;
                        CLS_ILL: begin
                            state_q      <= S_TRAP;
                            trap_cause_q <= TRAP_ILLEGAL;
                        end
                        default:  state_q <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    unique case (op_cls)
                        CLS_RALU, CLS_IALU: state_q <= S_WB;
                        CLS_LW, CLS_SW:     state_q <= S_MEM;
                        default:            state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (ready_eff) begin
                        state_q <= (op_cls == CLS_LW) ? S_WB : S_FETCH;
                    end else if (timed_out) begin
                        state_q      <= S_TRAP;
                        trap_cause_q <= TRAP_BUS;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_TRAP:  state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Datapath strobes decoded from state, latched opcode and live handshakes.
    always_comb begin
        pc_sel     = '0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        alu_ctrl   = '0;
        halted     = 1'b0;
        // NOTE: rst_n gates the decode directly so strobes drop the instant reset asserts, not at the next edge.
        if (rst_n) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (ready_eff) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_sel   = PCSEL_W'(PCSEL_INC);
                    end
                end
                S_EXEC: begin
                    unique case (op_cls)
                        CLS_RALU: alu_ctrl = ALUC_W'(op_q[3:0]);
                        CLS_IALU: begin
                            alu_ctrl = ALUC_W'({1'b0, op_q[2:0]});
                            alu_src  = 1'b1;
                        end
                        CLS_LW, CLS_SW: begin
                            alu_ctrl = ALUC_W'(ALU_ADD);
                            alu_src  = 1'b1;
                        end
                        CLS_BR: begin
                            alu_ctrl = ALUC_W'(ALU_SUB);
                            pc_write = br_taken;
                            pc_sel   = br_taken ? PCSEL_W'(PCSEL_BRANCH) : '0;
                        end
                        CLS_J: begin
                            pc_write = 1'b1;
                            pc_sel   = PCSEL_W'(PCSEL_JUMP);
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    iord      = 1'b1;
                    mem_read  = (op_cls == CLS_LW);
                    mem_write = (op_cls == CLS_SW);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (op_cls == CLS_LW);
                end
                S_TRAP: begin
                    pc_write = 1'b1;
                    pc_sel   = PCSEL_W'(PCSEL_TRAP);
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. An instruction-level model
// expands each instruction (plus planned memory wait counts) into the
// per-cycle strobe vectors it must produce; those go into a scoreboard
// queue that a negedge monitor pops and compares against the DUT.
module tb_multicycle_control;

    localparam int TMO = 15;

    typedef struct packed {
        logic [2:0] pc_sel;
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic [3:0] alu_ctrl;
        logic       halted;
        logic [1:0] trap_cause;
    } vec_t;

    typedef struct {
        vec_t  v;
        string tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] op = '0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] pc_sel;
    logic       pc_write, ir_write, iord, mem_read, mem_write;
    logic       mem_to_reg, alu_src, reg_write, halted;
    logic [3:0] alu_ctrl;
    logic [1:0] trap_cause;

    multicycle_control #(
        .OP_W(5), .ALUC_W(4), .PCSEL_W(3), .USE_READY(1), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_sel(pc_sel), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .reg_write(reg_write), .alu_ctrl(alu_ctrl),
        .halted(halted), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [1:0] m_cause = 2'd0;
    exp_t       mon_e;
    vec_t       mon_got;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h (pcsel,pcw,irw,iord,mrd,mwr,m2r,asrc,rw,aluc,halt,cause)",
                     tag, $time, got, exp);
        end
    endtask

    // Monitor: one expected vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_got = {pc_sel, pc_write, ir_write, iord, mem_read, mem_write,
                       mem_to_reg, alu_src, reg_write, alu_ctrl, halted, trap_cause};
            check(mon_e.tag, mon_got, mon_e.v);
        end
    end

    function automatic vec_t idle();
        vec_t v = '0;
        v.trap_cause = m_cause;
        return v;
    endfunction

    // One clock cycle: drive inputs just after the edge, queue the expectation.
    task automatic cyc(input logic rst, input logic rdy, input logic z,
                       input logic [4:0] o, input vec_t v, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rst;
        mem_ready = rdy;
        alu_zero  = z;
        op        = o;
        e.v       = v;
        e.tag     = tag;
        sb_q.push_back(e);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(1));
    endfunction

    task automatic do_reset(input int n);
        m_cause = 2'd0;
        for (int i = 0; i < n; i++) cyc(1'b0, rbit(), rbit(), 5'($urandom), idle(), "reset");
    endtask

    task automatic do_trap(input logic [1:0] cause, input logic [4:0] o);
        vec_t v;
        m_cause    = cause;
        v          = idle();
        v.pc_write = 1'b1;
        v.pc_sel   = 3'd4;
        cyc(1'b1, rbit(), rbit(), o, v, "trap");
    endtask

    // Memory phase: `waits` not-ready cycles, then ready; more than TMO waits traps.
    task automatic mem_phase(input bit is_fetch, input bit is_lw, input int waits,
                             input logic [4:0] o, output bit trapped);
        vec_t v;
        trapped = 1'b0;
        v = idle();
        if (is_fetch) v.mem_read = 1'b1;
        else begin
            v.iord      = 1'b1;
            v.mem_read  = is_lw;
            v.mem_write = !is_lw;
        end
        for (int i = 0; i <= TMO; i++) begin
            if (i == waits) begin
                if (is_fetch) begin
                    v.ir_write = 1'b1;
                    v.pc_write = 1'b1;
                end
                cyc(1'b1, 1'b1, rbit(), is_fetch ? 5'($urandom) : o, v,
                    is_fetch ? "fetch_done" : "mem_done");
                return;
            end
            cyc(1'b1, 1'b0, rbit(), is_fetch ? 5'($urandom) : o, v,
                is_fetch ? "fetch_wait" : "mem_wait");
        end
        do_trap(2'd2, o);
        trapped = 1'b1;
    endtask

    // Whole instruction from FETCH to its return to FETCH (or trap/halt).
    task automatic run_instr(input logic [4:0] o, input int fw, input int mw, input logic z);
        vec_t v;
        bit   tr;
        bit   taken;
        mem_phase(1'b1, 1'b0, fw, o, tr);
        if (tr) return;
        cyc(1'b1, rbit(), rbit(), o, idle(), "decode");
        v = idle();
        if (o == 5'h1E) return;
        if (o == 5'h1D) begin
            do_trap(2'd1, o);
            return;
        end
        if (o == 5'h1F) begin
            v.halted = 1'b1;
            for (int i = 0; i < 6; i++) cyc(1'b1, rbit(), rbit(), o, v, "halt");
            return;
        end
        if (o < 5'h10) begin
            v.alu_ctrl = o[3:0];
            cyc(1'b1, rbit(), rbit(), o, v, "exec_ralu");
        end else if (o < 5'h18) begin
            v.alu_ctrl = {1'b0, o[2:0]};
            v.alu_src  = 1'b1;
            cyc(1'b1, rbit(), rbit(), o, v, "exec_ialu");
        end else if (o == 5'h18 || o == 5'h19) begin
            v.alu_ctrl = 4'h0;
            v.alu_src  = 1'b1;
            cyc(1'b1, rbit(), rbit(), o, v, "exec_ldst");
            mem_phase(1'b0, o == 5'h18, mw, o, tr);
            if (tr || o == 5'h19) return;
        end else if (o == 5'h1A || o == 5'h1B) begin
            taken      = (o == 5'h1A) ? z : !z;
            v.alu_ctrl = 4'h1;
            v.pc_write = taken;
            v.pc_sel   = taken ? 3'd1 : 3'd0;
            cyc(1'b1, rbit(), z, o, v, "exec_branch");
            return;
        end else begin
            v.pc_write = 1'b1;
            v.pc_sel   = 3'd2;
            cyc(1'b1, rbit(), rbit(), o, v, "exec_jump");
            return;
        end
        v = idle();
        v.reg_write  = 1'b1;
        v.mem_to_reg = (o == 5'h18);
        cyc(1'b1, rbit(), rbit(), o, v, "writeback");
    endtask

    function automatic int rwait();
        int r = int'($urandom_range(19));
        if (r == 18) return TMO;
        if (r == 19) return TMO + 1;
        return r % 4;
    endfunction

    function automatic logic [4:0] rop();
        logic [4:0] o = 5'($urandom);
        while (o == 5'h1F) o = 5'($urandom);
        if ($urandom_range(2) == 0) o = 5'h18 + 5'($urandom_range(4));
        return o;
    endfunction

    initial begin
        vec_t v;
        bit   tr;
        do_reset(2);
        run_instr(5'h00, 0, 0, 1'b0);
        run_instr(5'h18, 0, 3, 1'b0);
        run_instr(5'h1A, 0, 0, 1'b1);
        run_instr(5'h1A, 1, 0, 1'b0);
        run_instr(5'h1B, 0, 0, 1'b0);
        run_instr(5'h1B, 0, 0, 1'b1);
        run_instr(5'h1C, 2, 0, 1'b0);
        run_instr(5'h1E, 0, 0, 1'b0);
        run_instr(5'h15, 0, 0, 1'b0);
        run_instr(5'h0F, TMO + 1, 0, 1'b0);
        run_instr(5'h03, TMO, 0, 1'b0);
        run_instr(5'h19, 0, TMO + 1, 1'b0);
        run_instr(5'h18, 0, TMO, 1'b0);
        run_instr(5'h1D, 0, 0, 1'b0);
        // SW interrupted by reset while waiting in MEM, with a trap cause pending.
        mem_phase(1'b1, 1'b0, 0, 5'h19, tr);
        cyc(1'b1, rbit(), rbit(), 5'h19, idle(), "decode");
        v = idle();
        v.alu_src = 1'b1;
        cyc(1'b1, rbit(), rbit(), 5'h19, v, "exec_ldst");
        v = idle();
        v.iord      = 1'b1;
        v.mem_write = 1'b1;
        cyc(1'b1, 1'b0, rbit(), 5'h19, v, "mem_wait");
        cyc(1'b1, 1'b0, rbit(), 5'h19, v, "mem_wait");
        do_reset(2);
        run_instr(5'h07, 0, 0, 1'b0);
        run_instr(5'h1F, 0, 0, 1'b0);
        do_reset(1);
        run_instr(5'h01, 0, 0, 1'b0);
        for (int n = 0; n < 150; n++) run_instr(rop(), rwait(), rwait(), rbit());
        run_instr(5'h1F, 1, 0, 1'b0);
        repeat (2) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vectors never compared, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
